// File: rtl/axi_mem_responder_if.sv
// AXI4 write/read channel bundle between an INCR-burst master and axi_mem_responder.
interface axi_mem_responder_if #(
  parameter int ID_WIDTH = 1,
  parameter int AWIDTH   = 64,
  parameter int DWIDTH   = 128
);
  logic [ID_WIDTH-1:0]   s_axi_awid;
  logic [AWIDTH-1:0]     s_axi_awaddr;
  logic [7:0]            s_axi_awlen;
  logic                  s_axi_awvalid;
  logic                  s_axi_awready;
  logic [DWIDTH-1:0]     s_axi_wdata;
  logic [DWIDTH/8-1:0]   s_axi_wstrb;
  logic                  s_axi_wlast;
  logic                  s_axi_wvalid;
  logic                  s_axi_wready;
  logic [ID_WIDTH-1:0]   s_axi_bid;
  logic [1:0]            s_axi_bresp;
  logic                  s_axi_bvalid;
  logic                  s_axi_bready;
  logic [ID_WIDTH-1:0]   s_axi_arid;
  logic [AWIDTH-1:0]     s_axi_araddr;
  logic [7:0]            s_axi_arlen;
  logic                  s_axi_arvalid;
  logic                  s_axi_arready;
  logic [ID_WIDTH-1:0]   s_axi_rid;
  logic [DWIDTH-1:0]     s_axi_rdata;
  logic [1:0]            s_axi_rresp;
  logic                  s_axi_rlast;
  logic                  s_axi_rvalid;
  logic                  s_axi_rready;

  modport master (
    output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awvalid,
    output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    output s_axi_bready,
    output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arvalid,
    output s_axi_rready,
    input  s_axi_awready, s_axi_wready,
    input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
    input  s_axi_arready,
    input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid
  );

  modport slave (
    input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awvalid,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    input  s_axi_bready,
    input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arvalid,
    input  s_axi_rready,
    output s_axi_awready, s_axi_wready,
    output s_axi_bid, s_axi_bresp, s_axi_bvalid,
    output s_axi_arready,
    output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid
  );
endinterface

// File: rtl/axi_mem_responder.sv
// AXI4 INCR-burst slave over a byte-writable synchronous RAM, one transaction at a time.
// Optional out-of-range burst checking is enabled by defining AXI_RSP_RANGE_CHECK_EN.
module axi_mem_responder #(
  parameter int ID_WIDTH = 1,
  parameter int AWIDTH   = 64,
  parameter int DWIDTH   = 128,
  parameter int DEPTH    = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  axi_mem_responder_if.slave axi
);
  localparam int STRB_W = DWIDTH / 8;
  localparam int OFS_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int SUM_W  = IDX_W + 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    WRESP = 2'd2,
    RDATA = 2'd3
  } state_t;

  state_t              state_r, state_nxt_s;
  logic                awready_r, arready_r, wready_r, bvalid_r;
  logic [1:0]          bresp_r, rresp_r;
  logic [ID_WIDTH-1:0] bid_r, rid_r;
  logic                rvalid_r, rlast_r;
  logic [DWIDTH-1:0]   rdata_r;
  logic                wr_pri_r;
  logic [IDX_W-1:0]    idx_r;
  logic [7:0]          cnt_r;
  logic [7:0]          rd_rem_r;
  logic                burst_err_r, wlast_err_r;
  logic                pend_r, pend_last_r;
  logic                skid_valid_r, skid_last_r;
  logic [DWIDTH-1:0]   skid_data_r;
  logic [DWIDTH-1:0]   ram_q_r;
  logic [DWIDTH-1:0]   mem [DEPTH];

  logic                aw_hs_s, ar_hs_s, w_hs_s, b_hs_s, r_pop_s;
  logic                gnt_wr_s, gnt_rd_s, arb_open_s;
  logic                wlast_bad_s, rd_room_s, rd_issue_s, rd_issue_last_s;
  logic [IDX_W-1:0]    aw_idx_s, ar_idx_s, rd_addr_s;
  logic                aw_oor_s, ar_oor_s;
  logic [1:0]          occ_s;
  logic [DWIDTH-1:0]   land_data_s;

  assign aw_hs_s  = axi.s_axi_awvalid && awready_r;
  assign ar_hs_s  = axi.s_axi_arvalid && arready_r;
  assign w_hs_s   = axi.s_axi_wvalid && wready_r;
  assign b_hs_s   = axi.s_axi_bready && bvalid_r;
  assign r_pop_s  = axi.s_axi_rready && rvalid_r;

  assign aw_idx_s = axi.s_axi_awaddr[OFS_W +: IDX_W];
  assign ar_idx_s = axi.s_axi_araddr[OFS_W +: IDX_W];

`ifdef AXI_RSP_RANGE_CHECK_EN
  assign aw_oor_s = (SUM_W'(aw_idx_s) + SUM_W'(axi.s_axi_awlen)) >= SUM_W'(DEPTH);
  assign ar_oor_s = (SUM_W'(ar_idx_s) + SUM_W'(axi.s_axi_arlen)) >= SUM_W'(DEPTH);
`else
  assign aw_oor_s = 1'b0;
  assign ar_oor_s = 1'b0;
`endif

  // A new decision is taken only in IDLE while no ready pulse is outstanding.
  assign arb_open_s  = (state_r == IDLE) && !awready_r && !arready_r;
  assign gnt_wr_s    = arb_open_s && axi.s_axi_awvalid && (!axi.s_axi_arvalid || wr_pri_r);
  assign gnt_rd_s    = arb_open_s && axi.s_axi_arvalid && (!axi.s_axi_awvalid || !wr_pri_r);
  assign wlast_bad_s = w_hs_s && (axi.s_axi_wlast != (cnt_r == 8'd0));

  // Output register, skid slot and the RAM read in flight together never exceed two beats.
  assign occ_s           = {1'b0, rvalid_r} + {1'b0, skid_valid_r} + {1'b0, pend_r};
  assign rd_room_s       = (occ_s < 2'd2) || ((occ_s == 2'd2) && r_pop_s);
  assign rd_issue_s      = ar_hs_s || ((state_r == RDATA) && (rd_rem_r != 8'd0) && rd_room_s);
  assign rd_issue_last_s = ar_hs_s ? (axi.s_axi_arlen == 8'd0) : (rd_rem_r == 8'd1);
  assign rd_addr_s       = ar_hs_s ? ar_idx_s : idx_r;
  assign land_data_s     = burst_err_r ? {DWIDTH{1'b0}} : ram_q_r;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (aw_hs_s) begin
          state_nxt_s = WDATA;
        end else if (ar_hs_s) begin
          state_nxt_s = RDATA;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WDATA: begin
        if (w_hs_s && (cnt_r == 8'd0)) begin
          state_nxt_s = WRESP;
        end else begin
          state_nxt_s = WDATA;
        end
      end
      WRESP: begin
        if (b_hs_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WRESP;
        end
      end
      RDATA: begin
        if (r_pop_s && rlast_r) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RDATA;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Handshake outputs, burst context and the read output buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awready_r    <= 1'b0;
      arready_r    <= 1'b0;
      wready_r     <= 1'b0;
      bvalid_r     <= 1'b0;
      bresp_r      <= 2'b00;
      bid_r        <= {ID_WIDTH{1'b0}};
      rid_r        <= {ID_WIDTH{1'b0}};
      rresp_r      <= 2'b00;
      rvalid_r     <= 1'b0;
      rlast_r      <= 1'b0;
      rdata_r      <= {DWIDTH{1'b0}};
      wr_pri_r     <= 1'b1;
      idx_r        <= {IDX_W{1'b0}};
      cnt_r        <= 8'd0;
      rd_rem_r     <= 8'd0;
      burst_err_r  <= 1'b0;
      wlast_err_r  <= 1'b0;
      pend_r       <= 1'b0;
      pend_last_r  <= 1'b0;
      skid_valid_r <= 1'b0;
      skid_last_r  <= 1'b0;
      skid_data_r  <= {DWIDTH{1'b0}};
    end else begin
      awready_r <= gnt_wr_s;
      arready_r <= gnt_rd_s;
      if (gnt_wr_s || gnt_rd_s) begin
        wr_pri_r <= gnt_rd_s;
      end

      if (aw_hs_s) begin
        idx_r       <= aw_idx_s;
        cnt_r       <= axi.s_axi_awlen;
        bid_r       <= axi.s_axi_awid;
        burst_err_r <= aw_oor_s;
        wlast_err_r <= 1'b0;
        wready_r    <= 1'b1;
      end

      if (w_hs_s) begin
        idx_r       <= idx_r + IDX_W'(1);
        cnt_r       <= cnt_r - 8'd1;
        wlast_err_r <= wlast_err_r | wlast_bad_s;
        if (cnt_r == 8'd0) begin
          wready_r <= 1'b0;
          bvalid_r <= 1'b1;
          bresp_r  <= (burst_err_r || wlast_err_r || wlast_bad_s) ? 2'b10 : 2'b00;
        end
      end

      if (b_hs_s) begin
        bvalid_r <= 1'b0;
      end

      if (ar_hs_s) begin
        rid_r       <= axi.s_axi_arid;
        burst_err_r <= ar_oor_s;
        rresp_r     <= ar_oor_s ? 2'b10 : 2'b00;
        rd_rem_r    <= axi.s_axi_arlen;
        idx_r       <= ar_idx_s + IDX_W'(1);
      end else if (rd_issue_s) begin
        rd_rem_r <= rd_rem_r - 8'd1;
        idx_r    <= idx_r + IDX_W'(1);
      end

      pend_r <= rd_issue_s;
      if (rd_issue_s) begin
        pend_last_r <= rd_issue_last_s;
      end

      // Oldest beat always sits in the output register; the skid slot absorbs one stalled beat.
      if (r_pop_s || !rvalid_r) begin
        if (skid_valid_r) begin
          rvalid_r     <= 1'b1;
          rdata_r      <= skid_data_r;
          rlast_r      <= skid_last_r;
          skid_valid_r <= pend_r;
          skid_data_r  <= land_data_s;
          skid_last_r  <= pend_last_r;
        end else if (pend_r) begin
          rvalid_r <= 1'b1;
          rdata_r  <= land_data_s;
          rlast_r  <= pend_last_r;
        end else begin
          rvalid_r <= 1'b0;
          rlast_r  <= 1'b0;
        end
      end else if (pend_r) begin
        skid_valid_r <= 1'b1;
        skid_data_r  <= land_data_s;
        skid_last_r  <= pend_last_r;
      end
    end
  end

  // Byte-strobed RAM write port and one-cycle-latency read port; contents survive reset
  always_ff @(posedge clk) begin
    if (w_hs_s && !burst_err_r) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (axi.s_axi_wstrb[b]) begin
          mem[idx_r][8*b +: 8] <= axi.s_axi_wdata[8*b +: 8];
        end
      end
    end
    if (rd_issue_s) begin
      ram_q_r <= mem[rd_addr_s];
    end
  end

  assign axi.s_axi_awready = awready_r;
  assign axi.s_axi_arready = arready_r;
  assign axi.s_axi_wready  = wready_r;
  assign axi.s_axi_bvalid  = bvalid_r;
  assign axi.s_axi_bresp   = bresp_r;
  assign axi.s_axi_bid     = bid_r;
  assign axi.s_axi_rvalid  = rvalid_r;
  assign axi.s_axi_rdata   = rdata_r;
  assign axi.s_axi_rresp   = rresp_r;
  assign axi.s_axi_rlast   = rlast_r;
  assign axi.s_axi_rid     = rid_r;
endmodule
